// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers returned words with
// their PCs in an in-order circular queue, and hands one instruction per cycle to decode.
// A redirect flushes the queue and counts still-due responses so they are discarded.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthCmp = (CntW + 1)'(DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     slot_pc_q [DEPTH];
  logic [31:0]     slot_pc_d [DEPTH];
  logic [31:0]     slot_instr_q [DEPTH];
  logic [31:0]     slot_instr_d [DEPTH];
  logic [DEPTH-1:0] slot_filled_q, slot_filled_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] alloc_q, alloc_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [CntW-1:0] alloc_cnt_q, alloc_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CntW-1:0] filled_cnt;
  logic [CntW:0]   occupancy;
  logic            grant, rsp_drop, rsp_fill, pop;
  logic            unused_redirect_lo;

  // Low address bits of a redirect target are ignored.
  assign unused_redirect_lo = ^redirect_pc[1:0];

  // Number of allocated slots already holding data; the rest still await a response.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CntW'(slot_filled_q[i]);
    end
  end

  // Outputs are derived from registered state only (plus redirect/reset for the request).
  assign occupancy = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
  assign imem_req  = !rst && !redirect_valid && (occupancy < DepthCmp);
  assign imem_addr = fetch_pc_q;
  assign if_valid  = (alloc_cnt_q != '0) && slot_filled_q[head_q];
  assign if_instr  = if_valid ? slot_instr_q[head_q] : Nop;
  assign if_pc     = if_valid ? slot_pc_q[head_q] : 32'h0;

  // Next-state: grant/response/pop apply together; redirect overrides and flushes.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    slot_pc_d     = slot_pc_q;
    slot_instr_d  = slot_instr_q;
    slot_filled_d = slot_filled_q;
    head_d        = head_q;
    alloc_d       = alloc_q;
    fill_d        = fill_q;
    alloc_cnt_d   = alloc_cnt_q;
    drop_cnt_d    = drop_cnt_q;

    grant    = imem_req && imem_gnt;
    rsp_drop = imem_rvalid && (drop_cnt_q != '0);
    rsp_fill = imem_rvalid && (drop_cnt_q == '0);
    pop      = if_valid && if_ready;

    if (redirect_valid) begin
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      slot_filled_d = '0;
      head_d        = '0;
      alloc_d       = '0;
      fill_d        = '0;
      alloc_cnt_d   = '0;
      // Every response still due is dropped; one arriving now is already accounted for,
      // either by consuming a pending slot or by retiring an earlier drop.
      drop_cnt_d    = drop_cnt_q + (alloc_cnt_q - filled_cnt) - CntW'(imem_rvalid);
    end else begin
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      if (rsp_fill) begin
        slot_instr_d[fill_q]  = imem_rdata;
        slot_filled_d[fill_q] = 1'b1;
        fill_d                = fill_q + PtrW'(1);
      end
      if (pop) begin
        slot_filled_d[head_q] = 1'b0;
        head_d                = head_q + PtrW'(1);
      end
      if (grant) begin
        slot_pc_d[alloc_q]     = fetch_pc_q;
        slot_filled_d[alloc_q] = 1'b0;
        alloc_d                = alloc_q + PtrW'(1);
        fetch_pc_d             = fetch_pc_q + 32'd4;
      end
      alloc_cnt_d = alloc_cnt_q + CntW'(grant) - CntW'(pop);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      slot_filled_q <= '0;
      head_q        <= '0;
      alloc_q       <= '0;
      fill_q        <= '0;
      alloc_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      slot_pc_q     <= slot_pc_d;
      slot_instr_q  <= slot_instr_d;
      slot_filled_q <= slot_filled_d;
      head_q        <= head_d;
      alloc_q       <= alloc_d;
      fill_q        <= fill_d;
      alloc_cnt_q   <= alloc_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, a full-throughput sequence and a
// long randomized run against a queue-based reference model with an in-order memory.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int total = 0;
  int bad   = 0;

  instr_fetch_queue #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  always #5 clk = ~clk;

  // Memory image: an arbitrary but fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    logic [31:0] ra;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit g, input bit v, input logic [31:0] ra,
                     input bit d, input logic [31:0] dpc, input bit y,
                     input bit er, input logic [31:0] ea, input bit ev,
                     input logic [31:0] ep);
    vec_t t;
    t.rst = r; t.gnt = g; t.rv = v; t.ra = ra; t.redir = d; t.rpc = dpc; t.rdy = y;
    t.e_req = er; t.e_addr = ea; t.e_valid = ev; t.e_pc = ep;
    vecs.push_back(t);
  endtask

  task automatic drive(input bit r, input bit g, input bit v, input logic [31:0] rd,
                       input bit d, input logic [31:0] dpc, input bit y);
    rst = r; imem_gnt = g; imem_rvalid = v; imem_rdata = rd;
    redirect_valid = d; redirect_pc = dpc; if_ready = y;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t        mdl[$];   // queue contents seen by decode, oldest first
  mreq_t       mq[$];    // requests granted to memory, responses still to return
  int          m_drop;
  logic [31:0] m_fetch;
  int          cyc;

  task automatic model_reset();
    mdl.delete();
    mq.delete();
    m_drop  = 0;
    m_fetch = RESET_PC;
    cyc     = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of model-driven traffic; fast selects full-rate, no-stall, 1-cycle memory.
  task automatic rand_cycle(input bit fast, output bit saw_valid);
    bit          g, rv, rd, rdy, e_req, e_valid, grant, done;
    logic [31:0] rp, rdat;
    int          unf;
    ent_t        e;
    mreq_t       r;
    @(posedge clk); #1;
    g   = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    rdy = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    rd  = fast ? 1'b0 : ($urandom_range(0, 39) == 0);
    rp  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
    rv   = 1'b0;
    rdat = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc && (fast || $urandom_range(0, 3) != 0)) begin
      rv   = 1'b1;
      rdat = mem_word(mq[0].addr);
    end
    drive(0, g, rv, rdat, rd, rp, rdy);
    @(negedge clk);
    e_req   = !rd && (mdl.size() + m_drop < DEPTH);
    e_valid = mdl.size() > 0 && mdl[0].filled;
    chk("rnd.req", 32'(imem_req), 32'(e_req));
    chk("rnd.addr", imem_addr, m_fetch);
    chk("rnd.valid", 32'(if_valid), 32'(e_valid));
    chk("rnd.pc", if_pc, e_valid ? mdl[0].pc : 32'h0);
    chk("rnd.instr", if_instr, e_valid ? mdl[0].instr : NOP);
    saw_valid = if_valid;
    grant = e_req && g;
    if (rv) begin
      mq.delete(0);
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        done = 1'b0;
        for (int i = 0; i < mdl.size(); i++) begin
          if (!done && !mdl[i].filled) begin
            mdl[i].filled = 1'b1;
            mdl[i].instr  = rdat;
            done = 1'b1;
          end
        end
      end
    end
    if (grant) begin
      r.addr = m_fetch;
      r.due  = cyc + (fast ? 1 : $urandom_range(1, 4));
      mq.push_back(r);
    end
    if (rd) begin
      unf = 0;
      foreach (mdl[i]) if (!mdl[i].filled) unf++;
      m_drop += unf;
      mdl.delete();
      m_fetch = {rp[31:2], 2'b00};
    end else begin
      if (e_valid && rdy) mdl.delete(0);
      if (grant) begin
        e.pc = m_fetch; e.instr = '0; e.filled = 1'b0;
        mdl.push_back(e);
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    bit sv;
    int vcnt;

    // Reset state, then 1-cycle memory at full rate.
    add(1,0,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,1, 1,32'h0,  0,32'h0);
    add(0,1,1,32'h0,  0,0,1, 1,32'h4,  0,32'h0);
    add(0,1,1,32'h4,  0,0,1, 1,32'h8,  1,32'h0);
    add(0,1,1,32'h8,  0,0,1, 1,32'hC,  1,32'h4);
    add(0,1,1,32'hC,  0,0,1, 1,32'h10, 1,32'h8);
    add(0,0,1,32'h10, 0,0,1, 1,32'h14, 1,32'hC);
    add(0,0,0,0,      0,0,1, 1,32'h14, 1,32'h10);
    add(0,0,0,0,      0,0,1, 1,32'h14, 0,32'h0);
    // Decode stalled: four grants fill the queue, then drain in order and resume at 0x10.
    add(1,0,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,1,1,32'h0,  0,0,0, 1,32'h4,  0,32'h0);
    add(0,1,1,32'h4,  0,0,0, 1,32'h8,  1,32'h0);
    add(0,1,1,32'h8,  0,0,0, 1,32'hC,  1,32'h0);
    add(0,1,1,32'hC,  0,0,0, 0,32'h10, 1,32'h0);
    add(0,1,0,0,      0,0,0, 0,32'h10, 1,32'h0);
    add(0,1,0,0,      0,0,1, 0,32'h10, 1,32'h0);
    add(0,1,0,0,      0,0,1, 1,32'h10, 1,32'h4);
    add(0,0,0,0,      0,0,1, 1,32'h14, 1,32'h8);
    add(0,0,1,32'h10, 0,0,1, 1,32'h14, 1,32'hC);
    add(0,0,0,0,      0,0,1, 1,32'h14, 1,32'h10);
    add(0,0,0,0,      0,0,0, 1,32'h14, 0,32'h0);
    // Two requests in flight (3-cycle latency), redirect to 0x102: both stale words dropped.
    add(1,0,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h4,  0,32'h0);
    add(0,1,0,0,      1,32'h102,0, 0,32'h8, 0,32'h0);
    add(0,1,1,32'h0,  0,0,0, 1,32'h100, 0,32'h0);
    add(0,1,1,32'h4,  0,0,0, 1,32'h104, 0,32'h0);
    add(0,0,0,0,      0,0,0, 1,32'h108, 0,32'h0);
    add(0,0,1,32'h100,0,0,1, 1,32'h108, 0,32'h0);
    add(0,0,1,32'h104,0,0,1, 1,32'h108, 1,32'h100);
    add(0,0,0,0,      0,0,1, 1,32'h108, 1,32'h104);
    add(0,0,0,0,      0,0,1, 1,32'h108, 0,32'h0);
    // Redirect coinciding with rvalid and if_ready: no pop, no leftover drop.
    add(1,0,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,1,1,32'h0,  0,0,0, 1,32'h4,  0,32'h0);
    add(0,0,0,0,      0,0,0, 1,32'h8,  1,32'h0);
    add(0,0,1,32'h4,  1,32'h200,1, 0,32'h8, 1,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h200, 0,32'h0);
    add(0,0,1,32'h200,0,0,0, 1,32'h204, 0,32'h0);
    add(0,0,0,0,      0,0,1, 1,32'h204, 1,32'h200);
    add(0,0,0,0,      0,0,0, 1,32'h204, 0,32'h0);
    // Reset with three requests outstanding; fetch restarts at RESET_PC.
    add(1,0,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h4,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h8,  0,32'h0);
    add(1,1,0,0,      0,0,0, 0,32'h0,  0,32'h0);
    add(0,0,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,1,0,0,      0,0,0, 1,32'h0,  0,32'h0);
    add(0,0,1,32'h0,  0,0,0, 1,32'h4,  0,32'h0);
    add(0,0,0,0,      0,0,1, 1,32'h4,  1,32'h0);

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      drive(vecs[k].rst, vecs[k].gnt, vecs[k].rv, mem_word(vecs[k].ra),
            vecs[k].redir, vecs[k].rpc, vecs[k].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d.req", k), 32'(imem_req), 32'(vecs[k].e_req));
      chk($sformatf("vec%0d.addr", k), imem_addr, vecs[k].e_addr);
      chk($sformatf("vec%0d.valid", k), 32'(if_valid), 32'(vecs[k].e_valid));
      chk($sformatf("vec%0d.pc", k), if_pc, vecs[k].e_valid ? vecs[k].e_pc : 32'h0);
      chk($sformatf("vec%0d.instr", k), if_instr,
          vecs[k].e_valid ? mem_word(vecs[k].e_pc) : NOP);
    end

    // Sustained throughput: valid every cycle from the third cycle on.
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      rand_cycle(1'b1, sv);
      if (i >= 2 && sv) vcnt++;
    end
    chk("throughput", 32'(vcnt), 32'd28);

    // Long randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rand_cycle(1'b0, sv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage directly upstream of decode and the immediate generator. Issues sequential word fetches to instruction memory over a request/grant/response handshake and buffers returned words with their PCs in a small in-order queue. Presents one instruction per cycle to decode with valid/ready flow control. Discards stale responses and restarts at a new PC on a branch/jump redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- DEPTH, 4, queue slots and maximum outstanding requests; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  word address of the request; held stable until granted
- imem_gnt  in  1  memory accepts the request this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  restart address; bits [1:0] forced to 0 internally
- if_valid  out  1  head instruction available to decode
- if_ready  in  1  decode accepts head instruction
- if_instr  out  32  head instruction; 32'h0000_0013 (NOP) whenever if_valid=0
- if_pc  out  32  PC of head instruction; 0 whenever if_valid=0

## Operation
- State: fetch_pc (32), circular slot array of DEPTH entries {pc, instr, filled}, head/alloc/fill pointers (log2(DEPTH) bits, wrap modulo DEPTH), alloc_count (0..DEPTH), drop_count (0..DEPTH).
- Request: imem_req = !redirect_valid && (alloc_count + drop_count < DEPTH); imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt): slot at alloc pointer gets pc=fetch_pc, filled=0; alloc pointer +1; alloc_count +1; fetch_pc += 4 (wraps mod 2^32).
- Response (imem_rvalid): if drop_count>0, drop_count −1 and data discarded; else instr written into slot at fill pointer, filled=1, fill pointer +1.
- Output: if_valid = alloc_count>0 && head slot filled. Pop on if_valid && if_ready: head +1, alloc_count −1.
- Redirect: all slots invalidated, pointers zeroed, alloc_count=0; drop_count += number of allocated-but-unfilled slots (granted requests with responses still due, excluding any response consumed this cycle); fetch_pc = {redirect_pc[31:2],2'b00}.
- Simultaneous events:
  - grant + response + pop in one cycle: all three apply; counters net correctly.
  - redirect + rvalid: that response belongs to old stream; counted/discarded consistently (never enters the new queue).
  - redirect + if_ready: pop ignored; queue cleared.
  - redirect never coincides with grant (imem_req low in redirect cycle).
- Full: alloc_count + drop_count = DEPTH → imem_req low, fetch_pc held.
- rvalid with no pending request is a protocol error; behaviour undefined.

## Timing
- During/after reset: imem_req=0 while rst high; fetch_pc=RESET_PC, all counters/pointers 0, if_valid=0, if_instr=NOP, if_pc=0.
- First imem_req high in first cycle after rst deasserts.
- imem_req, imem_addr, if_valid, if_instr, if_pc are combinational from registered state (plus redirect_valid for imem_req); no input→output path through rvalid/rdata.
- Response latency to decode: word returned in cycle N → if_valid in cycle N+1.
- Sustained throughput 1 instr/cycle with continuous grant, 1-cycle memory latency, if_ready high.
- Redirect in cycle N: fetch of redirect_pc requested in cycle N+1; if_valid low in N+1 at least.
- rst asserted mid-operation: immediate return to reset state; pending memory responses after reset are not tracked.

## Test plan
- Reset then 1-cycle memory, gnt=1, if_ready=1: imem_addr 0x0,0x4,0x8…; if_pc/if_instr follow one cycle after each rvalid; if_valid continuous from the 3rd cycle.
- if_ready=0 with DEPTH=4: exactly 4 grants, imem_req drops; if_ready→1 drains PCs 0x0–0xC in order and fetching resumes at 0x10.
- 2 requests outstanding (3-cycle latency), redirect to 0x0000_0102: next imem_addr 0x100; both old responses discarded; first if_pc 0x100.
- Redirect same cycle as rvalid and as if_ready: old word never appears on if_instr; no pop counted; drop_count returns to 0.
- Random gnt/rvalid latency/if_ready stalls over 10k cycles vs reference PC model: if_pc strictly +4 between redirects, if_instr matches memory image, if_instr=0x00000013 whenever if_valid=0.
- rst asserted with 3 outstanding: outputs reset asynchronously; after release first imem_addr = RESET_PC.
